// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants and state encoding for the nibble-serial adder sequencer.
// The FSM states and the nibble width are used by the controller and its interface users.
package adder_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble index width; a single-nibble add still needs a 1-bit index.
    function automatic int idx_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Requester-side bundle of the nibble-serial adder: start/operands in,
// busy/done/result out. The requester uses master; the controller uses slave.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_co;

    modport master (
        output start, op_a, op_b, op_cin,
        input  busy, done, result, result_co
    );

    modport slave (
        input  start, op_a, op_b, op_cin,
        output busy, done, result, result_co
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Drives an external 4-bit adder one nibble per clock (LSB nibble first),
// registering the carry between nibbles and assembling the WIDTH-bit sum.
module nibble_serial_add_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    nibble_serial_add_ctrl_if.slave  req,
    output logic [NIBBLE_W-1:0]      add_a,
    output logic [NIBBLE_W-1:0]      add_b,
    output logic                     add_cin,
    input  logic [NIBBLE_W-1:0]      add_sum,
    input  logic                     add_cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_next;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             result_co_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             accept;
    logic             in_run;
    logic             last_nib;

    logic [NIBBLE_W-1:0] a_nib [NIBBLES];
    logic [NIBBLE_W-1:0] b_nib [NIBBLES];

    assign in_run   = (state_reg == ST_RUN);
    assign last_nib = in_run && (idx_reg == LAST_IDX);

    // Per-nibble views of the operands, the working-sum update and the final assembly.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[NIBBLE_W*gi +: NIBBLE_W];
            assign b_nib[gi] = b_reg[NIBBLE_W*gi +: NIBBLE_W];

            assign work_next[NIBBLE_W*gi +: NIBBLE_W] =
                (idx_reg == IDX_W'(gi)) ? add_sum : work_reg[NIBBLE_W*gi +: NIBBLE_W];

            if (gi == NIBBLES - 1) begin : g_top
                assign result_next[NIBBLE_W*gi +: NIBBLE_W] = add_sum;
            end else begin : g_low
                assign result_next[NIBBLE_W*gi +: NIBBLE_W] = work_reg[NIBBLE_W*gi +: NIBBLE_W];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req.start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (req.start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            work_reg      <= '0;
            result_reg    <= '0;
            result_co_reg <= 1'b0;
        end else begin
            if (accept) begin
                a_reg     <= req.op_a;
                b_reg     <= req.op_b;
                carry_reg <= req.op_cin;
                idx_reg   <= '0;
                work_reg  <= '0;
            end else if (in_run) begin
                work_reg  <= work_next;
                carry_reg <= add_cout;
                // Park on the last index rather than wrapping; accept reloads it.
                if (!last_nib) begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
            if (last_nib) begin
                result_reg    <= result_next;
                result_co_reg <= add_cout;
            end
        end
    end

    // Adder pins come only from registered state and are quiet outside RUN.
    assign add_a   = in_run ? a_nib[idx_reg] : '0;
    assign add_b   = in_run ? b_nib[idx_reg] : '0;
    assign add_cin = in_run ? carry_reg : 1'b0;

    assign req.busy      = in_run;
    assign req.done      = (state_reg == ST_DONE);
    assign req.result    = result_reg;
    assign req.result_co = result_co_reg;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomised and directed check of the nibble-serial adder sequencer against
// plain integer arithmetic, with a behavioural 4-bit adder attached to add_*.
module tb_nibble_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(16)) req_if();

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;

    assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req_if.slave),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Carry entering nibble i = overflow of the sum of the lower i nibbles plus cin.
    function automatic logic [31:0] carry_into(input logic [15:0] a, input logic [15:0] b,
                                               input logic cin, input int i);
        logic [31:0] m;
        m = (32'd1 << (4 * i)) - 32'd1;
        return ((32'(a) & m) + (32'(b) & m) + 32'(cin)) >> (4 * i);
    endfunction

    task automatic drive_req(input logic [15:0] a, input logic [15:0] b, input logic cin);
        req_if.start  = 1'b1;
        req_if.op_a   = a;
        req_if.op_b   = b;
        req_if.op_cin = cin;
    endtask

    // Called just after a negedge with start already driven; returns at a negedge.
    task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic cin,
                           input bit poke, input logic [15:0] pa, input logic [15:0] pb,
                           input bit chain, input logic [15:0] ca, input logic [15:0] cb,
                           input logic ccin);
        int          cyc;
        bit          seen;
        logic [16:0] exp_sum;
        exp_sum = 17'(a) + 17'(b) + 17'(cin);
        @(posedge clk);
        @(negedge clk);
        req_if.start  = 1'b0;
        req_if.op_a   = 16'($urandom);
        req_if.op_b   = 16'($urandom);
        req_if.op_cin = 1'($urandom);
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 10 && !seen) begin
            if (req_if.done) begin
                seen = 1'b1;
            end else begin
                check("busy_run", 32'(req_if.busy), 32'd1);
                if (cyc < 4) begin
                    check("add_a", 32'(add_a), 32'((a >> (4 * cyc)) & 16'hF));
                    check("add_b", 32'(add_b), 32'((b >> (4 * cyc)) & 16'hF));
                    check("add_cin", 32'(add_cin), carry_into(a, b, cin, cyc));
                end
                if (poke && cyc == 1) begin
                    drive_req(pa, pb, 1'b0);
                end else begin
                    req_if.start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", 32'(cyc), 32'd4);
        check("result", 32'(req_if.result), 32'(exp_sum[15:0]));
        check("result_co", 32'(req_if.result_co), 32'(exp_sum[16]));
        check("busy_in_done", 32'(req_if.busy), 32'd0);
        $display("txn a=%04h b=%04h cin=%0d -> result=%04h co=%0d (expect %04h/%0d)",
                 a, b, cin, req_if.result, req_if.result_co, exp_sum[15:0], exp_sum[16]);
        if (chain) begin
            drive_req(ca, cb, ccin);
        end else begin
            req_if.start = 1'b0;
            @(negedge clk);
            check("done_pulse", 32'(req_if.done), 32'd0);
            check("idle_adder_pins", {23'd0, add_a, add_b, add_cin}, 32'd0);
        end
    endtask

    logic [15:0] ra, rb, na, nb;
    logic        rc, nc;
    bit          pending, chain_now;

    initial begin
        req_if.start  = 1'b0;
        req_if.op_a   = '0;
        req_if.op_b   = '0;
        req_if.op_cin = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(req_if.busy), 32'd0);
        check("rst_done", 32'(req_if.done), 32'd0);
        check("rst_result", 32'(req_if.result), 32'd0);
        check("rst_result_co", 32'(req_if.result_co), 32'd0);
        check("rst_adder_pins", {23'd0, add_a, add_b, add_cin}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        drive_req(16'h0003, 16'h0005, 1'b0);
        run_add(16'h0003, 16'h0005, 1'b0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1'b0);
        drive_req(16'hFFFF, 16'h0001, 1'b0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1'b0);
        drive_req(16'hFFFF, 16'hFFFF, 1'b1);
        run_add(16'hFFFF, 16'hFFFF, 1'b1, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1'b0);

        // Start mid-RUN is ignored; start during DONE chains the next add.
        drive_req(16'h1234, 16'h1111, 1'b0);
        run_add(16'h1234, 16'h1111, 1'b0, 1, 16'h0F0F, 16'h0101, 1, 16'h0F0F, 16'h0101, 1'b0);
        run_add(16'h0F0F, 16'h0101, 1'b0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1'b0);

        // Reset while the third nibble is on the adder.
        drive_req(16'h7000, 16'h9000, 1'b0);
        @(posedge clk);
        @(negedge clk);
        req_if.start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_busy", 32'(req_if.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(req_if.busy), 32'd0);
        check("midrst_done", 32'(req_if.done), 32'd0);
        check("midrst_result", 32'(req_if.result), 32'd0);
        check("midrst_adder_pins", {23'd0, add_a, add_b, add_cin}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(req_if.done), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'(req_if.busy), 32'd0);
        drive_req(16'h7000, 16'h9000, 1'b0);
        run_add(16'h7000, 16'h9000, 1'b0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1'b0);

        pending = 1'b0;
        ra = '0;
        rb = '0;
        rc = 1'b0;
        for (int t = 0; t < 24; t++) begin
            if (!pending) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom);
                drive_req(ra, rb, rc);
            end
            na = 16'($urandom);
            nb = 16'($urandom);
            nc = 1'($urandom);
            chain_now = (t != 23) && ($urandom_range(0, 2) == 0);
            run_add(ra, rb, rc, 1'($urandom), 16'($urandom), 16'($urandom),
                    chain_now, na, nb, nc);
            if (chain_now) begin
                ra = na;
                rb = nb;
                rc = nc;
            end
            pending = chain_now;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
